// File: rtl/frog_pkg.sv
// Shared definitions for the frogger object engine.
//   KEY_*        USB HID arrow keycodes recognised as hop requests
//   LANE_PITCH   vertical distance between successive log lanes
//   hop_state_t  frog FSM states (IDLE, HOP)
//   hop_dir_t    direction latched for the hop in progress
//   is_arrow()   true for any of the four arrow keycodes
package frog_pkg;

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_UP    = 8'h52;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DOWN  = 8'h51;

    localparam int LANE_PITCH = 32;

    typedef enum logic {
        IDLE,
        HOP
    } hop_state_t;

    typedef enum logic [1:0] {
        H_LEFT,
        H_UP,
        H_RIGHT,
        H_DOWN
    } hop_dir_t;

    function automatic logic is_arrow(input logic [7:0] k);
        return (k == KEY_LEFT) || (k == KEY_UP) || (k == KEY_RIGHT) || (k == KEY_DOWN);
    endfunction

endpackage

// File: rtl/log_lane.sv
// One scrolling log lane.
//   frame_clk  frame clock
//   Reset_n    asynchronous active-low reset, loads init_x
//   speed      pixels per frame (0 freezes the lane)
//   dir        1 = scroll right, 0 = scroll left
//   init_x     left edge after reset (tie to a constant)
//   log_x      registered left edge, always in [0, SCREEN_W-1]
//   delta      signed lane velocity for this frame (two's complement)
module log_lane #(
    parameter int COORD_W  = 11,
    parameter int SCREEN_W = 640
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic [3:0]         speed,
    input  logic               dir,
    input  logic [COORD_W-1:0] init_x,
    output logic [COORD_W-1:0] log_x,
    output logic [4:0]         delta
);

    localparam logic [COORD_W-1:0] SCREEN = COORD_W'(SCREEN_W);

    logic [COORD_W-1:0] spd;
    logic [COORD_W-1:0] log_x_nxt;

    assign spd   = COORD_W'(speed);
    assign delta = dir ? {1'b0, speed} : (5'd0 - {1'b0, speed});

    // Speed never exceeds 15, so one conditional add/subtract of the
    // screen width is enough to stay inside [0, SCREEN_W-1].
    always_comb begin
        log_x_nxt = log_x;
        if (dir) begin
            log_x_nxt = log_x + spd;
            if (log_x_nxt >= SCREEN)
                log_x_nxt = log_x_nxt - SCREEN;
        end else begin
            if (log_x >= spd)
                log_x_nxt = log_x - spd;
            else
                log_x_nxt = log_x + SCREEN - spd;
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n)
            log_x <= init_x;
        else
            log_x <= log_x_nxt;
    end

endmodule

// File: rtl/frog_lane_mover.sv
// Frame-rate game-object engine for frogger: frog hop FSM, log lanes,
// ride/drown logic. All state advances once per frame_clk.
//   frame_clk     frame (vsync-rate) clock
//   Reset_n       asynchronous active-low reset
//   keycode       current USB keycode; arrow edges start hops
//   lane_speed    per-lane speed, lane i at [4i+3:4i]
//   lane_dir      per-lane direction, 1 = right
//   FrogX/FrogY   frog centre, FrogS frog half-size (constant)
//   LogX/LogY     per-lane log left edge / row, lane i at [W*i +: W]
//   LogS          log length (constant)
//   frog_on_log   frog idle and riding a log
//   frog_hopping  hop FSM in HOP
//   splash        one-frame pulse when the frog drowns
// Optional build macro FROG_LIVES_EN adds lives[1:0] and game_over.
module frog_lane_mover
    import frog_pkg::*;
#(
    parameter int NUM_LANES    = 4,
    parameter int COORD_W      = 11,
    parameter int SCREEN_W     = 640,
    parameter int FROG_X_START = 320,
    parameter int FROG_Y_START = 440,
    parameter int FROG_SIZE    = 4,
    parameter int HOP_STEP     = 4,
    parameter int HOP_FRAMES   = 8,
    parameter int LANE_Y0      = 56,
    parameter int LOG_LEN      = 96,
    parameter int FROG_Y_MIN   = 24
) (
    input  logic                         frame_clk,
    input  logic                         Reset_n,
    input  logic [7:0]                   keycode,
    input  logic [4*NUM_LANES-1:0]       lane_speed,
    input  logic [NUM_LANES-1:0]         lane_dir,
    output logic [COORD_W-1:0]           FrogX,
    output logic [COORD_W-1:0]           FrogY,
    output logic [COORD_W-1:0]           FrogS,
    output logic [COORD_W*NUM_LANES-1:0] LogX,
    output logic [COORD_W*NUM_LANES-1:0] LogY,
    output logic [COORD_W-1:0]           LogS,
    output logic                         frog_on_log,
    output logic                         frog_hopping,
    output logic                         splash
`ifdef FROG_LIVES_EN
    ,
    output logic [1:0]                   lives,
    output logic                         game_over
`endif
);

    localparam int CNT_W   = $clog2(HOP_FRAMES);
    localparam int SW      = COORD_W + 2;
    localparam int HOP_PIX = HOP_STEP * HOP_FRAMES;
    localparam int X_MIN   = FROG_SIZE;
    localparam int X_MAX   = SCREEN_W - 1 - FROG_SIZE;

    localparam logic [COORD_W-1:0]   STEP      = COORD_W'(HOP_STEP);
    localparam logic [COORD_W-1:0]   SCREEN    = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0]   LOG_LEN_C = COORD_W'(LOG_LEN);
    localparam logic signed [SW-1:0] X_MIN_S   = SW'(X_MIN);
    localparam logic signed [SW-1:0] X_MAX_S   = SW'(X_MAX);

    hop_state_t         state, state_nxt;
    hop_dir_t           dir_q, dir_nxt, req_dir;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [7:0]         key_prev;
    logic [COORD_W-1:0] frog_x_nxt, frog_y_nxt;
    logic               on_log_nxt, splash_nxt;

    logic [COORD_W-1:0] log_x [NUM_LANES];
    logic [4:0]         delta [NUM_LANES];

    logic               on_lane, covered;
    logic [4:0]         lane_delta;
    logic signed [SW-1:0] carry_sum;
    logic [COORD_W-1:0] carry_x, base_x;
    logic               press, dest_ok, frozen;

    assign FrogS        = COORD_W'(FROG_SIZE);
    assign LogS         = LOG_LEN_C;
    assign frog_hopping = (state == HOP);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        log_lane #(
            .COORD_W  (COORD_W),
            .SCREEN_W (SCREEN_W)
        ) u_lane (
            .frame_clk (frame_clk),
            .Reset_n   (Reset_n),
            .speed     (lane_speed[4*i +: 4]),
            .dir       (lane_dir[i]),
            .init_x    (COORD_W'(i * (SCREEN_W / NUM_LANES))),
            .log_x     (log_x[i]),
            .delta     (delta[i])
        );
        assign LogX[COORD_W*i +: COORD_W] = log_x[i];
        assign LogY[COORD_W*i +: COORD_W] = COORD_W'(LANE_Y0 + i * LANE_PITCH);
    end

    // Distance from the log's left edge to the frog, modulo the screen;
    // a log straddling the wrap point is handled for free.
    function automatic logic [COORD_W-1:0] span_off(input logic [COORD_W-1:0] fx,
                                                    input logic [COORD_W-1:0] lx);
        if (fx >= lx)
            return fx - lx;
        else
            return fx + SCREEN - lx;
    endfunction

    // Lane rows are distinct, so at most one lane can match.
    always_comb begin
        on_lane    = 1'b0;
        covered    = 1'b0;
        lane_delta = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (FrogY == COORD_W'(LANE_Y0 + i * LANE_PITCH)) begin
                on_lane    = 1'b1;
                lane_delta = delta[i];
                covered    = span_off(FrogX, log_x[i]) < LOG_LEN_C;
            end
        end
    end

    // Carried X, clamped to the legal frog range.
    always_comb begin
        carry_sum = signed'({2'b00, FrogX}) + signed'({{(SW-5){lane_delta[4]}}, lane_delta});
        if (carry_sum < X_MIN_S)
            carry_x = COORD_W'(X_MIN);
        else if (carry_sum > X_MAX_S)
            carry_x = COORD_W'(X_MAX);
        else
            carry_x = carry_sum[COORD_W-1:0];
    end

    // A hop started while riding departs from the carried position, so the
    // landing check uses that position too.
    always_comb begin
        base_x  = (on_lane && covered) ? carry_x : FrogX;
        press   = is_arrow(keycode) && (keycode != key_prev);
        req_dir = H_UP;
        dest_ok = 1'b0;
        case (keycode)
            KEY_LEFT:  begin req_dir = H_LEFT;  dest_ok = base_x >= COORD_W'(X_MIN + HOP_PIX); end
            KEY_RIGHT: begin req_dir = H_RIGHT; dest_ok = base_x <= COORD_W'(X_MAX - HOP_PIX); end
            KEY_UP:    begin req_dir = H_UP;    dest_ok = FrogY >= COORD_W'(FROG_Y_MIN + HOP_PIX); end
            KEY_DOWN:  begin req_dir = H_DOWN;  dest_ok = FrogY <= COORD_W'(FROG_Y_START - HOP_PIX); end
            default:   begin req_dir = H_UP;    dest_ok = 1'b0; end
        endcase
    end

    // Frog FSM. Drowning wins over a simultaneous hop request.
    always_comb begin
        state_nxt  = state;
        dir_nxt    = dir_q;
        cnt_nxt    = cnt;
        frog_x_nxt = FrogX;
        frog_y_nxt = FrogY;
        on_log_nxt = 1'b0;
        splash_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (on_lane && !covered) begin
                    splash_nxt = 1'b1;
                    frog_x_nxt = COORD_W'(FROG_X_START);
                    frog_y_nxt = COORD_W'(FROG_Y_START);
                end else begin
                    frog_x_nxt = base_x;
                    if (press && dest_ok && !frozen) begin
                        state_nxt = HOP;
                        dir_nxt   = req_dir;
                        cnt_nxt   = '0;
                    end else begin
                        on_log_nxt = on_lane;
                    end
                end
            end
            HOP: begin
                case (dir_q)
                    H_LEFT:  frog_x_nxt = FrogX - STEP;
                    H_RIGHT: frog_x_nxt = FrogX + STEP;
                    H_UP:    frog_y_nxt = FrogY - STEP;
                    default: frog_y_nxt = FrogY + STEP;
                endcase
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == CNT_W'(HOP_FRAMES - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            dir_q       <= H_UP;
            cnt         <= '0;
            FrogX       <= COORD_W'(FROG_X_START);
            FrogY       <= COORD_W'(FROG_Y_START);
            key_prev    <= 8'h00;
            frog_on_log <= 1'b0;
            splash      <= 1'b0;
        end else begin
            state       <= state_nxt;
            dir_q       <= dir_nxt;
            cnt         <= cnt_nxt;
            FrogX       <= frog_x_nxt;
            FrogY       <= frog_y_nxt;
            key_prev    <= keycode;
            frog_on_log <= on_log_nxt;
            splash      <= splash_nxt;
        end
    end

`ifdef FROG_LIVES_EN
    // Once the last life is gone the frog stays parked; logs keep scrolling.
    assign frozen = game_over;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lives     <= 2'd3;
            game_over <= 1'b0;
        end else if (splash_nxt && (lives != 2'd0)) begin
            lives <= lives - 2'd1;
            if (lives == 2'd1)
                game_over <= 1'b1;
        end
    end
`else
    assign frozen = 1'b0;
`endif

endmodule

// File: tb/tb_frog_lane_mover.sv
// Bench for frog_lane_mover: directed scenarios followed by random key and
// lane traffic. A frame-level reference model predicts every frame's outputs
// into exp_q; an independent monitor compares them after each clock edge.
`timescale 1ns/1ps
module tb_frog_lane_mover;

    localparam int NL     = 4;
    localparam int CW     = 11;
    localparam int OBS_W  = 2*CW + NL*CW + 3;
    localparam int SCR    = 640;

    // ---------------- clock / reset ----------------
    logic             frame_clk = 1'b0;
    logic             Reset_n   = 1'b0;
    logic [7:0]       keycode   = 8'h00;
    logic [4*NL-1:0]  lane_speed = '0;
    logic [NL-1:0]    lane_dir   = '0;

    logic [CW-1:0]    FrogX, FrogY, FrogS, LogS;
    logic [CW*NL-1:0] LogX, LogY;
    logic             frog_on_log, frog_hopping, splash;

    always #5 frame_clk = ~frame_clk;

    frog_lane_mover dut (
        .frame_clk    (frame_clk),
        .Reset_n      (Reset_n),
        .keycode      (keycode),
        .lane_speed   (lane_speed),
        .lane_dir     (lane_dir),
        .FrogX        (FrogX),
        .FrogY        (FrogY),
        .FrogS        (FrogS),
        .LogX         (LogX),
        .LogY         (LogY),
        .LogS         (LogS),
        .frog_on_log  (frog_on_log),
        .frog_hopping (frog_hopping),
        .splash       (splash)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [OBS_W-1:0] exp_q[$];

    // ---------------- reference model ----------------
    int m_fx, m_fy, m_hop_left, m_hdx, m_hdy, m_prev;
    int m_lx[NL];
    bit m_on, m_spl;
    int spd[NL];
    bit dirv[NL];

    task automatic model_reset();
        m_fx = 320; m_fy = 440; m_hop_left = 0; m_hdx = 0; m_hdy = 0; m_prev = 0;
        m_on = 1'b0; m_spl = 1'b0;
        for (int i = 0; i < NL; i++) m_lx[i] = i * (SCR / NL);
    endtask

    function automatic int clampx(input int x);
        if (x < 4) return 4;
        if (x > 635) return 635;
        return x;
    endfunction

    function automatic logic [OBS_W-1:0] model_obs();
        logic [OBS_W-1:0] v;
        v = '0;
        v[OBS_W-1 -: CW]    = CW'(m_fx);
        v[OBS_W-1-CW -: CW] = CW'(m_fy);
        for (int i = 0; i < NL; i++) v[3 + CW*i +: CW] = CW'(m_lx[i]);
        v[2] = m_on;
        v[1] = (m_hop_left > 0);
        v[0] = m_spl;
        return v;
    endfunction

    function automatic logic [OBS_W-1:0] dut_obs();
        return {FrogX, FrogY, LogX, frog_on_log, frog_hopping, splash};
    endfunction

    function automatic string fmt(input logic [OBS_W-1:0] v);
        return $sformatf("fx=%0d fy=%0d lx=%0d/%0d/%0d/%0d on=%0b hop=%0b spl=%0b",
                         v[OBS_W-1 -: CW], v[OBS_W-1-CW -: CW], v[3+3*CW +: CW],
                         v[3+2*CW +: CW], v[3+CW +: CW], v[3 +: CW], v[2], v[1], v[0]);
    endfunction

    task automatic compare(input string name, input logic [OBS_W-1:0] got,
                           input logic [OBS_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got {%s} expected {%s}", name, $time, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge frame_clk) begin
        #1;
        if (exp_q.size() > 0) compare("frame", dut_obs(), exp_q.pop_front());
    end

    // ---------------- driver tasks ----------------
    // Drive one frame's inputs (caller is at a negedge) and predict the
    // outputs that will be visible after the next rising edge.
    task automatic apply_frame(input logic [7:0] k);
        int v[NL];
        int nlx[NL];
        int nfx, nfy, base_x, lane, dx, dy, tx, ty;
        bit press, cov, start;
        keycode = k;
        for (int i = 0; i < NL; i++) begin
            lane_speed[4*i +: 4] = 4'(spd[i]);
            lane_dir[i]          = dirv[i];
        end
        press  = (k == 8'h50 || k == 8'h52 || k == 8'h4F || k == 8'h51) && (int'(k) != m_prev);
        m_prev = int'(k);
        for (int i = 0; i < NL; i++) begin
            v[i]   = dirv[i] ? spd[i] : -spd[i];
            nlx[i] = (m_lx[i] + v[i] + SCR) % SCR;
        end
        nfx = m_fx; nfy = m_fy; m_on = 1'b0; m_spl = 1'b0;
        if (m_hop_left > 0) begin
            nfx = m_fx + 4 * m_hdx;
            nfy = m_fy + 4 * m_hdy;
            m_hop_left--;
        end else begin
            lane = -1;
            for (int i = 0; i < NL; i++) if (m_fy == 56 + 32 * i) lane = i;
            cov = 1'b0;
            if (lane >= 0) cov = ((m_fx - m_lx[lane] + SCR) % SCR) < 96;
            if (lane >= 0 && !cov) begin
                m_spl = 1'b1; nfx = 320; nfy = 440;
            end else begin
                base_x = (lane >= 0) ? clampx(m_fx + v[lane]) : m_fx;
                nfx    = base_x;
                start  = 1'b0;
                if (press) begin
                    dx = 0; dy = 0;
                    case (k)
                        8'h50:   dx = -1;
                        8'h4F:   dx = 1;
                        8'h52:   dy = -1;
                        default: dy = 1;
                    endcase
                    tx = base_x + 32 * dx;
                    ty = m_fy + 32 * dy;
                    if (tx >= 4 && tx <= 635 && ty >= 24 && ty <= 440) begin
                        start = 1'b1; m_hop_left = 8; m_hdx = dx; m_hdy = dy;
                    end
                end
                m_on = (lane >= 0) && !start;
            end
        end
        m_fx = nfx; m_fy = nfy;
        for (int i = 0; i < NL; i++) m_lx[i] = nlx[i];
        exp_q.push_back(model_obs());
    endtask

    task automatic drive_frame(input logic [7:0] k);
        @(negedge frame_clk);
        apply_frame(k);
    endtask

    // One key press followed by enough idle frames for the hop to finish.
    task automatic hop(input logic [7:0] k);
        drive_frame(k);
        repeat (9) drive_frame(8'h00);
    endtask

    // Asynchronous reset in the middle of a frame, checked immediately.
    task automatic do_reset();
        @(posedge frame_clk);
        #3;
        Reset_n = 1'b0;
        keycode = 8'h00;
        model_reset();
        #1 compare("reset_async", dut_obs(), model_obs());
        repeat (2) @(negedge frame_clk);
        Reset_n = 1'b1;
        apply_frame(8'h00);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog t=%0t bench did not complete", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < NL; i++) begin spd[i] = 0; dirv[i] = 1'b0; end
        model_reset();
        #12;
        compare("reset_state", dut_obs(), model_obs());
        check_int("frog_size", int'(FrogS), 4);
        check_int("log_len", int'(LogS), 96);
        for (int i = 0; i < NL; i++) check_int("log_y", int'(LogY[CW*i +: CW]), 56 + 32 * i);
        @(negedge frame_clk);
        Reset_n = 1'b1;
        apply_frame(8'h00);
        repeat (2) drive_frame(8'h00);

        // Held up-arrow: exactly one hop.
        repeat (20) drive_frame(8'h52);
        drive_frame(8'h00);

        // Fast right-moving lane 0 wraps past the screen edge.
        spd[0] = 15; dirv[0] = 1'b1;
        repeat (43) drive_frame(8'h00);
        @(posedge frame_clk); #2;
        check_int("lane0_wrap", int'(LogX[0 +: CW]), (43 * 15) % SCR);
        spd[0] = 0;

        // Lanes frozen: walk up onto lane 3 with no log under the frog.
        do_reset();
        repeat (9) hop(8'h52);
        repeat (4) drive_frame(8'h00);

        // Line up with lane 3's log, ride it to the right clamp.
        repeat (5) hop(8'h4F);
        repeat (9) hop(8'h52);
        spd[3] = 2; dirv[3] = 1'b1;
        repeat (78) drive_frame(8'h00);
        @(posedge frame_clk); #2;
        check_int("ride_clamp_x", int'(FrogX), 635);
        check_int("ride_on_log", int'(frog_on_log), 1);
        repeat (6) drive_frame(8'h00);

        // Left edge: a hop that would leave the screen is dropped.
        repeat (9) hop(8'h50);
        hop(8'h50);
        @(posedge frame_clk); #2;
        check_int("left_reject_x", int'(FrogX), 32);
        check_int("left_reject_hop", int'(frog_hopping), 0);

        // Reset in the middle of a hop.
        drive_frame(8'h4F);
        repeat (3) drive_frame(8'h00);
        do_reset();

        // Random traffic.
        for (int seg = 0; seg < 500; seg++) begin
            int r, n;
            logic [7:0] k;
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < NL; i++) begin
                    spd[i]  = $urandom_range(0, 15);
                    dirv[i] = 1'($urandom_range(0, 1));
                end
            end
            r = $urandom_range(0, 99);
            if (r < 45)      k = 8'h52;
            else if (r < 60) k = 8'h50;
            else if (r < 75) k = 8'h4F;
            else if (r < 85) k = 8'h51;
            else if (r < 93) k = 8'h00;
            else             k = 8'($urandom_range(0, 255));
            n = $urandom_range(1, 12);
            repeat (n) drive_frame(k);
            if (seg == 250) do_reset();
        end

        @(posedge frame_clk); #2;
        check_int("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
